// File: rtl/mem_access_pkg.sv
// Shared constants and helpers for the memory-access stage:
// size encodings, FSM states, store lane formatting and legality checks.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  function automatic logic [3:0] f_strb(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    case (f3[1:0])
      2'd0:    f_strb = 4'b0001 << a;
      2'd1:    f_strb = 4'b0011 << {a[1], 1'b0};
      default: f_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_repl(
    input logic [2:0]  f3,
    input logic [31:0] d
  );
    case (f3[1:0])
      2'd0:    f_repl = {4{d[7:0]}};
      2'd1:    f_repl = {2{d[15:0]}};
      default: f_repl = d;
    endcase
  endfunction

  function automatic logic f_misaligned(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    case (f3[1:0])
      2'd1:    f_misaligned = a[0];
      2'd2:    f_misaligned = |a;
      default: f_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic f_ld_ok(input logic [2:0] f3);
    f_ld_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
              (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic f_st_ok(input logic [2:0] f3);
    f_st_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load data alignment: picks the addressed byte/half from the
// read word and sign- or zero-extends it to 32 bits.
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_alo,
  input  logic [2:0]  i_f3,
  output logic [31:0] o_val
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // select the addressed byte and half-word lanes
  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_alo)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_alo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // extend the selected lane according to the access size
  always_comb begin
    o_val = i_rdata;
    case (i_f3)
      F3_B:    o_val = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_val = {24'd0, w_byte};
      F3_H:    o_val = {{16{w_half[15]}}, w_half};
      F3_HU:   o_val = {16'd0, w_half};
      default: o_val = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: one data-memory transaction per record,
// load alignment, timeout guard and a registered writeback record.
module mem_access_stage
  import mem_access_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_load,
  input  logic            in_store,
  input  logic            in_we_reg,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [4:0]      in_rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_load;
  logic [1:0]      r_alo;
  logic [2:0]      r_f3;
  logic [XLEN-1:0] w_ld_val;
  logic            w_mem;
  logic            w_err;
  logic            w_tmo;

  assign in_ready = (r_state == S_IDLE) && !RST;

  assign w_mem = in_load | in_store;
  assign w_err = (in_load & in_store) |
                 (in_load & ~f_ld_ok(in_funct3)) |
                 (in_store & ~f_st_ok(in_funct3)) |
                 (w_mem & f_misaligned(in_funct3, in_addr[1:0]));
  assign w_tmo = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

  load_align u_align (
    .i_rdata (mem_rdata),
    .i_alo   (r_alo),
    .i_f3    (r_f3),
    .o_val   (w_ld_val)
  );

  // FSM, memory request registers and writeback record
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_load    <= 1'b0;
      r_alo     <= 2'd0;
      r_f3      <= 3'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= 4'd0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= '0;
      wb_err    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_load <= in_load;
            r_alo  <= in_addr[1:0];
            r_f3   <= in_funct3;
            wb_rd  <= in_rd;
            r_cnt  <= '0;
            if (w_mem && !w_err) begin
              r_state   <= S_REQ;
              mem_req   <= 1'b1;
              mem_we    <= in_store;
              mem_addr  <= {in_addr[XLEN-1:2], 2'b00};
              mem_wdata <= in_store ? f_repl(in_funct3, in_wdata) : '0;
              mem_wstrb <= in_store ? f_strb(in_funct3, in_addr[1:0])
                                    : 4'd0;
            end else begin
              r_state  <= S_RESP;
              wb_valid <= 1'b1;
              wb_err   <= w_err;
              wb_we    <= !w_err && !w_mem && in_we_reg && (in_rd != 5'd0);
              wb_data  <= (w_err || w_mem) ? '0 : in_addr;
            end
          end
        end
        S_REQ: begin
          if (mem_ack || w_tmo) begin
            r_state   <= S_RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= 4'd0;
            wb_valid  <= 1'b1;
            wb_err    <= !mem_ack;
            wb_we     <= mem_ack && r_load && (wb_rd != 5'd0);
            wb_data   <= (mem_ack && r_load) ? w_ld_val : '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_state  <= S_IDLE;
          wb_valid <= 1'b0;
          wb_we    <= 1'b0;
          wb_err   <= 1'b0;
          wb_data  <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage directly downstream of the ALU/control stage of the scheme CPU core.
- Consumes one retired-execute record per handshake: ALU result as address or value, store data, load/store/we_reg flags, rd, funct3.
- Performs at most one data-memory transaction per record, aligns load data, and emits one registered writeback record to the register-file stage.
- Stalls upstream through in_ready while a transaction is outstanding.

Parameters:
XLEN, 32, data/address width (only 32 supported)
TIMEOUT, 255, max cycles mem_req may wait for mem_ack before error; 0 disables timeout

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
in_valid  in  1  upstream record valid
in_ready  out  1  stage can accept a record
in_load  in  1  record is a load
in_store  in  1  record is a store
in_we_reg  in  1  record writes rd
in_funct3  in  3  size/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU
in_addr  in  32  ALU result (address for load/store, value otherwise)
in_wdata  in  32  rs2 value for stores
in_rd  in  5  destination register
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = write
mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_wstrb  out  4  byte enables
mem_ack  in  1  request completed; mem_rdata valid this cycle for reads
mem_rdata  in  32  read word
wb_valid  out  1  one-cycle pulse, writeback record valid
wb_we  out  1  write rd
wb_rd  out  5  destination
wb_data  out  32  writeback value
wb_err  out  1  misaligned/illegal-size/timeout

Behaviour:
- Reset: state IDLE, in_ready=0 while RST high, all other outputs 0, timeout counter 0. Reset mid-transaction abandons it; mem_req falls asynchronously, no wb record.
- FSM IDLE, REQ, RESP. in_ready=1 only in IDLE with RST low. Record accepted on in_valid&in_ready at rising edge; all fields latched.
- Non-memory record: IDLE->RESP. Next cycle wb_valid=1, wb_data=in_addr, wb_we=in_we_reg&(rd!=0), wb_err=0. Latency 1.
- Load/store, aligned: IDLE->REQ. mem_req=1 from next cycle, outputs stable until the cycle mem_ack=1, which samples mem_rdata. REQ->RESP; wb_valid the cycle after ack. Minimum latency 2 (ack on first req cycle).
- Store: mem_we=1. strb B 4'b0001<<a[1:0], H 4'b0011<<{a[1],1'b0}, W 4'b1111. wdata B {4{d[7:0]}}, H {2{d[15:0]}}, W d. wb_we=0, wb_data=0.
- Load: select byte a[1:0] / half a[1] from mem_rdata; B/H sign-extend, BU/HU zero-extend, W raw. wb_we=(rd!=0). mem_wstrb=0.
- Misaligned (H with a[0]=1, W with a[1:0]!=0) or illegal funct3 (3,6,7 on load; >2 on store): no mem_req, IDLE->RESP, wb_valid next cycle with wb_err=1, wb_we=0, wb_data=0.
- Timeout: counter increments each REQ cycle without ack. After TIMEOUT cycles, mem_req drops, REQ->RESP, wb_err=1, wb_we=0. Late ack in RESP/IDLE is ignored.
- RESP->IDLE unconditionally; wb_* hold one cycle, then wb_valid=0. Back-to-back throughput: one record per 2 cycles minimum.
- in_load&in_store both set: treated as illegal, wb_err=1.

Decomposition:
- Package mem_access_pkg: funct3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), FSM state enum, strb/replicate function, misalign-check function.
- Sub-module load_align: combinational byte/half select and sign/zero extension (rdata, a[1:0], funct3 -> 32-bit value).

Test Plan:
- ALU record in_addr=0x0000_002A, rd=5, we_reg=1 -> wb_valid 1 cycle later, wb_data=0x2A, wb_we=1, no mem_req.
- SB addr=0x103, wdata=0x1234_56AB -> mem_addr=0x100, wstrb=4'b1000, wdata=0xABAB_ABAB; ack after 3 cycles -> wb_valid next cycle, wb_we=0.
- LB addr=0x202, rdata=0x0080_0000 -> wb_data=0xFFFF_FF80; LBU same -> 0x0000_0080; LH addr=0x202, rdata=0x8001_0000 -> 0xFFFF_8001.
- LW addr=0x206 -> no mem_req, wb_err=1, wb_we=0 next cycle; LW rd=0 aligned -> wb_we=0.
- TIMEOUT=4, store never acked -> mem_req high exactly 4 cycles, then wb_err=1; late ack ignored, in_ready returns.
- RST pulsed while in REQ -> mem_req=0 immediately, no wb_valid; after release, a new LW completes normally.
